// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared RAM geometry, loader widths and loader state encoding
package program_loader_pkg;
   localparam int RAM_BYTES   = 16;
   localparam int ADDR_W      = 4;
   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;
endpackage

// File: rtl/program_loader_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous pin with a registered rising-edge pulse
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise
);
   logic [STAGES-1:0] sync;
   logic              prev;
   // shift the pin through the chain and register a one-cycle pulse on its synchronised rise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
         rise <= sync[STAGES-1] & ~prev;
      end
   end
   assign level = sync[STAGES-1];
endmodule

// File: rtl/program_loader.sv
// program_loader: writes program bytes from the pins into RAM through the MAR/RAM strobes while holding the CPU
module program_loader
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_mode,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              n_load_addr,
   output logic              n_load_data,
   output logic              n_write,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   output logic [ADDR_W-1:0] addr
);
   state_t            state, next;
   logic              mode, vpulse, mode_rise_unused;
   logic [DATA_W-1:0] data_q;
   logic              last;

   sync_edge #(.STAGES(SYNC_STAGES)) u_valid (
      .clk(clk), .rst_n(rst_n), .d(data_valid), .level(), .rise(vpulse)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_mode (
      .clk(clk), .rst_n(rst_n), .d(load_mode), .level(mode), .rise(mode_rise_unused)
   );

   assign last = addr == ADDR_W'(RAM_BYTES - 1);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else state <= next;
   end

   // next state; dropping load_mode abandons a byte unless its RAM write is already under way
   always_comb begin
      next = S_IDLE;
      unique case (state)
         S_IDLE:  next = mode ? S_WAIT : S_IDLE;
         S_WAIT:  next = !mode ? S_IDLE : vpulse ? S_ADDR : S_WAIT;
         S_ADDR:  next = mode ? S_DATA : S_IDLE;
         S_DATA:  next = mode ? S_WRITE : S_IDLE;
         S_WRITE: next = last ? S_DONE : mode ? S_WAIT : S_IDLE;
         S_DONE:  next = mode ? S_DONE : S_IDLE;
         default: next = S_IDLE;
      endcase
   end

   // address counter, accepted byte and sticky overrun; a byte offered while busy is dropped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr    <= '0;
         data_q  <= '0;
         overrun <= 1'b0;
      end else begin
         if (state == S_IDLE && mode) addr <= '0;
         else if (state == S_WRITE) addr <= addr + 1'b1;
         if (state == S_WAIT && vpulse) data_q <= data_in;
         if (state == S_IDLE && mode) overrun <= 1'b0;
         else if (vpulse && busy) overrun <= 1'b1;
      end
   end

   // strobes and bus drive decoded from the state
   always_comb begin
      bus_oe      = state == S_ADDR || state == S_DATA;
      bus_out     = state == S_ADDR ? {{(DATA_W-ADDR_W){1'b0}}, addr} : state == S_DATA ? data_q : '0;
      n_load_addr = state != S_ADDR;
      n_load_data = state != S_DATA;
      n_write     = state != S_WRITE;
      cpu_hold    = state != S_IDLE;
      busy        = state == S_ADDR || state == S_DATA || state == S_WRITE;
      done        = state == S_DONE;
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: vector table, directed corner sequences and random loads checked against a byte-level model
module tb_program_loader;
   import program_loader_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, load_mode = 1'b0, data_valid = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  bus_out;
   logic        bus_oe, n_load_addr, n_load_data, n_write, cpu_hold, busy, done, overrun;
   logic [3:0]  addr;

   program_loader dut (
      .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .data_valid(data_valid), .data_in(data_in),
      .bus_out(bus_out), .bus_oe(bus_oe), .n_load_addr(n_load_addr), .n_load_data(n_load_data),
      .n_write(n_write), .cpu_hold(cpu_hold), .busy(busy), .done(done), .overrun(overrun), .addr(addr)
   );

   always #5 clk = ~clk;

   // MAR and RAM as seen on the shared bus
   logic [3:0] mar = 4'h0;
   logic [7:0] mdr = 8'h00;
   logic [7:0] ram [16];
   int         writes = 0;
   always @(posedge clk) begin
      if (!n_load_addr) mar <= bus_out[3:0];
      if (!n_load_data) mdr <= bus_out;
      if (!n_write) begin
         ram[mar] <= mdr;
         writes   <= writes + 1;
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] obs();
      return {bus_oe, bus_out, n_load_addr, n_load_data, n_write, busy, cpu_hold, done, overrun, addr};
   endfunction

   function automatic logic [19:0] mk(input logic oe, input logic [7:0] bus, input logic nla, input logic nld,
                                      input logic nw, input logic bsy, input logic hold, input logic dn,
                                      input logic ovr, input logic [3:0] a);
      return {oe, bus, nla, nld, nw, bsy, hold, dn, ovr, a};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("strobes_vs_busy", 32'(int'(!n_load_addr) + int'(!n_load_data) + int'(!n_write)), 32'(busy));
      end
   endtask

   task automatic set_mode(input logic v);
      load_mode = v;
      cyc(4);
   endtask

   task automatic offer(input logic [7:0] b, input int h, input int l);
      data_in    = b;
      data_valid = 1'b1;
      cyc(h);
      data_valid = 1'b0;
      cyc(l);
   endtask

   task automatic double_offer(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      cyc(1);
      data_valid = 1'b0;
      cyc(1);
      data_valid = 1'b1;
      cyc(1);
      data_valid = 1'b0;
   endtask

   typedef struct {
      logic        lm;
      logic        dv;
      logic [7:0]  din;
      logic [19:0] exp;
   } vec_t;

   initial begin
      vec_t        vecs [10];
      logic [19:0] idle_v, wait_v;
      int          w0, m_cnt;
      logic [3:0]  m_addr;
      logic        m_ovr;
      logic [7:0]  m_ram [16];
      logic [7:0]  b;
      int          h;

      idle_v = mk(0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 4'd0);
      wait_v = mk(0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 4'd0);
      vecs[0] = '{1'b1, 1'b0, 8'hA5, idle_v};
      vecs[1] = '{1'b1, 1'b0, 8'hA5, idle_v};
      vecs[2] = '{1'b1, 1'b0, 8'hA5, wait_v};
      vecs[3] = '{1'b1, 1'b1, 8'hA5, wait_v};
      vecs[4] = '{1'b1, 1'b1, 8'hA5, wait_v};
      vecs[5] = '{1'b1, 1'b1, 8'hA5, wait_v};
      vecs[6] = '{1'b1, 1'b0, 8'hA5, mk(1, 8'h00, 0, 1, 1, 1, 1, 0, 0, 4'd0)};
      vecs[7] = '{1'b1, 1'b0, 8'hA5, mk(1, 8'hA5, 1, 0, 1, 1, 1, 0, 0, 4'd0)};
      vecs[8] = '{1'b1, 1'b0, 8'hA5, mk(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 4'd0)};
      vecs[9] = '{1'b1, 1'b0, 8'hA5, mk(0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 4'd1)};

      // reset
      cyc(2);
      chk("reset_outputs", 32'(obs()), 32'(idle_v));
      rst_n = 1'b1;

      // single byte, cycle by cycle
      foreach (vecs[i]) begin
         load_mode  = vecs[i].lm;
         data_valid = vecs[i].dv;
         data_in    = vecs[i].din;
         cyc(1);
         chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      end
      chk("ram0_a5", 32'(ram[0]), 32'h0A5);

      // full 16-byte program, wrap, ignored 17th strobe
      set_mode(1'b0);
      set_mode(1'b1);
      chk("reentry_addr", 32'(addr), 32'd0);
      for (int i = 0; i < 16; i++) begin
         offer(8'h10 + 8'(i), 1 + i % 3, 8);
         chk($sformatf("prog_addr%0d", i), 32'(addr), 32'((i + 1) % 16));
         chk($sformatf("prog_done%0d", i), 32'(done), 32'(i == 15));
      end
      for (int i = 0; i < 16; i++) chk($sformatf("prog_ram%0d", i), 32'(ram[i]), 32'(8'h10 + 8'(i)));
      w0 = writes;
      offer(8'hEE, 2, 8);
      chk("extra_writes", 32'(writes), 32'(w0));
      chk("extra_state", 32'(obs()), 32'(mk(0, 8'h00, 1, 1, 1, 0, 1, 1, 0, 4'd0)));
      set_mode(1'b0);
      chk("done_exit", 32'(obs()), 32'(idle_v));

      // second strobe while busy
      set_mode(1'b1);
      w0 = writes;
      double_offer(8'h3C);
      cyc(10);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_writes", 32'(writes), 32'(w0 + 1));
      chk("ovr_addr", 32'(addr), 32'd1);
      chk("ovr_ram0", 32'(ram[0]), 32'h03C);

      // load_mode dropped while the byte is in DATA
      w0 = writes;
      data_in    = 8'h77;
      data_valid = 1'b1;
      cyc(3);
      load_mode  = 1'b0;
      data_valid = 1'b0;
      cyc(1);
      chk("abort_addr_phase", 32'(n_load_addr), 32'd0);
      cyc(1);
      chk("abort_data_phase", 32'(obs()), 32'(mk(1, 8'h77, 1, 0, 1, 1, 1, 0, 1, 4'd1)));
      cyc(1);
      chk("abort_idle", 32'(obs()), 32'(mk(0, 8'h00, 1, 1, 1, 0, 0, 0, 1, 4'd1)));
      cyc(2);
      chk("abort_writes", 32'(writes), 32'(w0));
      set_mode(1'b1);
      chk("abort_reentry", 32'(obs()), 32'(wait_v));

      // reset during WRITE
      double_offer(8'h99);
      cyc(3);
      chk("rst_write_phase", 32'(obs()), 32'(mk(0, 8'h00, 1, 1, 0, 1, 1, 0, 1, 4'd0)));
      rst_n = 1'b0;
      cyc(1);
      chk("rst_mid_write", 32'(obs()), 32'(idle_v));
      cyc(1);
      chk("rst_hold", 32'(obs()), 32'(idle_v));
      rst_n = 1'b1;
      set_mode(1'b0);

      // random program with occasional dropped second strobes
      set_mode(1'b1);
      m_cnt  = 0;
      m_addr = 4'd0;
      m_ovr  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         m_ram[m_addr] = b;
         if ($urandom_range(0, 3) == 0) begin
            double_offer(b);
            cyc(9);
            m_ovr = 1'b1;
         end else begin
            h = $urandom_range(1, 3);
            offer(b, h, 8 - h + $urandom_range(0, 2));
         end
         m_cnt++;
         m_addr = 4'(m_cnt % RAM_BYTES);
         chk($sformatf("rnd_addr%0d", i), 32'(addr), 32'(m_addr));
         chk($sformatf("rnd_done%0d", i), 32'(done), 32'(m_cnt == RAM_BYTES));
         chk($sformatf("rnd_ovr%0d", i), 32'(overrun), 32'(m_ovr));
      end
      for (int i = 0; i < 16; i++) chk($sformatf("rnd_ram%0d", i), 32'(ram[i]), 32'(m_ram[i]));
      set_mode(1'b0);
      chk("rnd_exit", 32'(cpu_hold), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
